// File: rtl/credit_receiver_buffer.sv
// ============================================================================
// Module      : credit_receiver_buffer
// Description : Receive end of a credit-based link. Holds pushes in a
//               NUM_CREDITS-deep circular buffer and returns one credit per pop.
//               Optional macro CREDIT_RECEIVER_FALLTHROUGH_EN adds an
//               empty-buffer bypass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module credit_receiver_buffer #(
    parameter int NUM_CREDITS = 4,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          valid_i,
    input  logic [DATA_WIDTH-1:0]         data_i,
    output logic                          valid_o,
    output logic [DATA_WIDTH-1:0]         data_o,
    input  logic                          ready_i,
    output logic                          credit_give_o,
    output logic [$clog2(NUM_CREDITS):0]  usage_o,
    output logic                          overflow_o
);

    localparam int PTR_W = (NUM_CREDITS > 1) ? $clog2(NUM_CREDITS) : 1;
    localparam int USE_W = $clog2(NUM_CREDITS) + 1;

    localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(NUM_CREDITS - 1);
    localparam logic [USE_W-1:0] c_full_use = USE_W'(NUM_CREDITS);

    logic [DATA_WIDTH-1:0] r_mem [NUM_CREDITS];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [USE_W-1:0]      r_usage;
    logic                  r_credit;
    logic                  r_overflow;

    logic w_empty;
    logic w_full;
    logic w_bypass;
    logic w_pop_any;
    logic w_pop_mem;
    logic w_push;
    logic w_ovf;

    assign w_empty = (r_usage == '0);
    assign w_full  = (r_usage == c_full_use);

`ifdef CREDIT_RECEIVER_FALLTHROUGH_EN
    // Empty buffer: the incoming push is presented directly and, if taken,
    // never touches storage.
    assign w_bypass = w_empty & valid_i & ready_i;
    assign valid_o  = w_empty ? valid_i : 1'b1;
    assign data_o   = w_empty ? data_i : r_mem[r_rd_ptr];
`else
    assign w_bypass = 1'b0;
    assign valid_o  = !w_empty;
    assign data_o   = r_mem[r_rd_ptr];
`endif

    assign w_pop_any = valid_o & ready_i;
    assign w_pop_mem = w_pop_any & !w_empty;
    // A push into a full buffer is dropped even when a pop frees a slot
    // in the same cycle; the sender had no credit for it.
    assign w_push    = valid_i & !w_full & !w_bypass;
    assign w_ovf     = valid_i & w_full;

    assign usage_o       = r_usage;
    assign credit_give_o = r_credit;
    assign overflow_o    = r_overflow;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_usage    <= '0;
            r_credit   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_credit <= w_pop_any;
            if (w_ovf) begin
                r_overflow <= 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_mem) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop_mem})
                2'b10:   r_usage <= r_usage + USE_W'(1);
                2'b01:   r_usage <= r_usage - USE_W'(1);
                default: r_usage <= r_usage;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_credit_receiver_buffer.sv
// ============================================================================
// Module      : tb_credit_receiver_buffer
// Description : Directed self-checking bench for credit_receiver_buffer
//               (depth 4 instance plus a depth 3 instance for pointer wrap).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_credit_receiver_buffer;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;

    logic        a_flush = 1'b0, a_valid_i = 1'b0, a_ready = 1'b0;
    logic [31:0] a_data_i = '0;
    logic        a_valid_o, a_credit, a_ovf;
    logic [31:0] a_data_o;
    logic [2:0]  a_usage;

    logic        b_flush = 1'b0, b_valid_i = 1'b0, b_ready = 1'b0;
    logic [31:0] b_data_i = '0;
    logic        b_valid_o, b_credit, b_ovf;
    logic [31:0] b_data_o;
    logic [2:0]  b_usage;

    int total = 0;
    int bad   = 0;
    int b_credit_cnt = 0;

    always #5 clk = ~clk;

    credit_receiver_buffer #(.NUM_CREDITS(4), .DATA_WIDTH(32)) u_dut_a (
        .clk_i(clk), .rst_i(rst_i), .flush_i(a_flush),
        .valid_i(a_valid_i), .data_i(a_data_i),
        .valid_o(a_valid_o), .data_o(a_data_o), .ready_i(a_ready),
        .credit_give_o(a_credit), .usage_o(a_usage), .overflow_o(a_ovf)
    );

    credit_receiver_buffer #(.NUM_CREDITS(3), .DATA_WIDTH(32)) u_dut_b (
        .clk_i(clk), .rst_i(rst_i), .flush_i(b_flush),
        .valid_i(b_valid_i), .data_i(b_data_i),
        .valid_o(b_valid_o), .data_o(b_data_o), .ready_i(b_ready),
        .credit_give_o(b_credit), .usage_o(b_usage), .overflow_o(b_ovf)
    );

    always @(negedge clk) begin
        if (!rst_i && b_credit === 1'b1) b_credit_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change 1 ns later, checks run after a further 1 ns.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held two cycles while a push is being offered
        a_valid_i = 1'b1; a_data_i = 32'hFF;
        tick(); tick();
        a_valid_i = 1'b0;
        #1;
        chk("rst_usage",  32'(a_usage),  0);
        chk("rst_valid",  32'(a_valid_o), 0);
        chk("rst_credit", 32'(a_credit), 0);
        chk("rst_ovf",    32'(a_ovf),    0);
        rst_i = 1'b0;
        tick();

        // Fill A..D with no consumer
        for (int i = 1; i <= 4; i++) begin
            a_valid_i = 1'b1; a_data_i = 32'hAAAA_0000 + 32'(i);
            tick();
        end
        a_valid_i = 1'b0;
        #1;
        chk("fill_usage", 32'(a_usage),  4);
        chk("fill_valid", 32'(a_valid_o), 1);
        chk("fill_head",  a_data_o,      32'hAAAA_0001);
        chk("fill_credit",32'(a_credit), 0);

        // Drain in order, credit lags each pop by one cycle
        a_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_data",   a_data_o,      32'hAAAA_0001 + 32'(k));
            chk("drain_credit", 32'(a_credit), (k > 0) ? 32'd1 : 32'd0);
            tick();
        end
        a_ready = 1'b0;
        #1;
        chk("drain_last_credit", 32'(a_credit),  1);
        chk("drain_usage",       32'(a_usage),   0);
        chk("drain_valid",       32'(a_valid_o), 0);
        tick();
        chk("drain_credit_end",  32'(a_credit),  0);

        // Overflow: push into full buffer alongside a pop
        for (int i = 1; i <= 4; i++) begin
            a_valid_i = 1'b1; a_data_i = 32'hBBBB_0000 + 32'(i);
            tick();
        end
        a_data_i = 32'hEEEE_EEEE; a_ready = 1'b1;
        #1;
        chk("ovf_head", a_data_o, 32'hBBBB_0001);
        tick();
        a_valid_i = 1'b0; a_ready = 1'b0;
        #1;
        chk("ovf_flag",   32'(a_ovf),    1);
        chk("ovf_credit", 32'(a_credit), 1);
        chk("ovf_usage",  32'(a_usage),  3);
        chk("ovf_head2",  a_data_o,      32'hBBBB_0002);
        tick();
        chk("ovf_sticky", 32'(a_ovf),    1);
        chk("ovf_credit0",32'(a_credit), 0);
        a_ready = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            chk("ovf_drain", a_data_o, 32'hBBBB_0000 + 32'(k));
            tick();
        end
        a_ready = 1'b0;
        #1;
        chk("ovf_empty", 32'(a_usage), 0);
        tick();

        // Flush with two entries and a coincident pop
        for (int i = 1; i <= 2; i++) begin
            a_valid_i = 1'b1; a_data_i = 32'hCCCC_0000 + 32'(i);
            tick();
        end
        a_valid_i = 1'b0;
        #1;
        chk("pre_flush_usage", 32'(a_usage), 2);
        a_flush = 1'b1; a_ready = 1'b1;
        tick();
        a_flush = 1'b0; a_ready = 1'b0;
        #1;
        chk("flush_usage",  32'(a_usage),   0);
        chk("flush_valid",  32'(a_valid_o), 0);
        chk("flush_credit", 32'(a_credit),  0);
        chk("flush_ovf",    32'(a_ovf),     0);
        tick();
        chk("flush_no_credit", 32'(a_credit), 0);

        // Push into empty buffer with consumer ready
        a_valid_i = 1'b1; a_data_i = 32'h5A; a_ready = 1'b1;
        #1;
`ifdef CREDIT_RECEIVER_FALLTHROUGH_EN
        chk("ft_valid_same", 32'(a_valid_o), 1);
        chk("ft_data_same",  a_data_o,       32'h5A);
        tick();
        a_valid_i = 1'b0; a_ready = 1'b0;
        #1;
        chk("ft_usage",  32'(a_usage),  0);
        chk("ft_credit", 32'(a_credit), 1);
        chk("ft_valid",  32'(a_valid_o), 0);
`else
        chk("reg_valid_same", 32'(a_valid_o), 0);
        tick();
        a_valid_i = 1'b0;
        #1;
        chk("reg_valid_next", 32'(a_valid_o), 1);
        chk("reg_data_next",  a_data_o,       32'h5A);
        chk("reg_credit",     32'(a_credit),  0);
        tick();
        a_ready = 1'b0;
        #1;
        chk("reg_credit_pop", 32'(a_credit), 1);
        chk("reg_usage",      32'(a_usage),  0);
`endif
        tick();

        // Depth-3 instance: ten push/pop pairs wrap both pointers
        for (int i = 0; i < 10; i++) begin
            b_valid_i = 1'b1; b_ready = 1'b0; b_data_i = 32'hD000_0000 + 32'(i);
            tick();
            b_valid_i = 1'b0; b_ready = 1'b1;
            #1;
            chk("wrap_valid", 32'(b_valid_o), 1);
            chk("wrap_data",  b_data_o,       32'hD000_0000 + 32'(i));
            tick();
        end
        b_ready = 1'b0;
        tick(); tick();
        chk("wrap_usage",   32'(b_usage),  0);
        chk("wrap_credits", 32'(b_credit_cnt), 10);
        chk("wrap_ovf",     32'(b_ovf),    0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
